req_encoder16_4: RTL and testbench

REQ_ENCODER16_4 -- requirements
Module: req_encoder16_4

---
 rtl/req_encoder16_4.sv | 76 +++++++
 tb/tb_req_encoder16_4.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/req_encoder16_4.sv
// req_encoder16_4: sticky 16-source request encoder with fixed-priority or round-robin grant and ack handshake
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   req        - request lines, one per source (level or pulse)
//   mask       - 1 = source selectable, 0 = held pending only
//   mode       - 0 = lowest index wins, 1 = round-robin after last acked id
//   ack        - consumer accepts id_out (only meaningful while valid)
//   valid      - registered, id_out holds a granted source
//   id_out     - registered binary index of the granted source
//   onehot_out - one-hot of id_out while valid, else 0
//   pending    - registered sticky pending vector
module req_encoder16_4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] mask,
    input  logic        mode,
    input  logic        ack,
    output logic        valid,
    output logic [3:0]  id_out,
    output logic [15:0] onehot_out,
    output logic [15:0] pending
);
    logic [3:0]  ptr;
    logic        take;
    logic        free;
    logic [15:0] clr;
    logic [15:0] pending_next;
    logic [15:0] cand;
    logic [3:0]  start;
    logic [3:0]  idx;
    logic [3:0]  sel;
    logic        found;

    assign onehot_out   = valid ? (16'd1 << id_out) : 16'd0;
    assign take         = valid & ack;
    assign free         = ~valid | ack;
    assign clr          = take ? onehot_out : 16'd0;
    // a new request on the bit being cleared keeps it pending
    assign pending_next = (pending & ~clr) | req;
    assign cand         = pending_next & mask;
    // ptr is updated on this same edge when acking, so search from the id being acked
    assign start        = mode ? ((take ? id_out : ptr) + 4'd1) : 4'd0;

    always_comb begin
        sel   = 4'd0;
        found = 1'b0;
        idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx = start + 4'(i);
            if (!found && cand[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 16'd0;
            valid   <= 1'b0;
            id_out  <= 4'd0;
            ptr     <= 4'hF;
        end else begin
            pending <= pending_next;
            if (take)
                ptr <= id_out;
            if (free) begin
                valid <= found;
                if (found)
                    id_out <= sel;
            end
        end
    end
endmodule

// File: tb/tb_req_encoder16_4.sv
// tb_req_encoder16_4: directed self-checking bench for req_encoder16_4
module tb_req_encoder16_4;
    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] mask;
    logic        mode;
    logic        ack;
    logic        valid;
    logic [3:0]  id_out;
    logic [15:0] onehot_out;
    logic [15:0] pending;
    int          checks;
    int          errors;

    req_encoder16_4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mask       (mask),
        .mode       (mode),
        .ack        (ack),
        .valid      (valid),
        .id_out     (id_out),
        .onehot_out (onehot_out),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req  = 16'h0000;
        mask = 16'hFFFF;
        mode = 1'b0;
        ack  = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 16'h0000;
        mask   = 16'hFFFF;
        mode   = 1'b0;
        ack    = 1'b0;
        #22;
        chk("rst_valid", 16'(valid), 16'h0000);
        chk("rst_id", 16'(id_out), 16'h0000);
        chk("rst_pending", pending, 16'h0000);
        chk("rst_onehot", onehot_out, 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // idle after release
        tick(); tick(); tick();
        chk("idle_valid", 16'(valid), 16'h0000);
        chk("idle_pending", pending, 16'h0000);
        chk("idle_onehot", onehot_out, 16'h0000);

        // fixed priority drain of a single pulse
        req = 16'h8014;
        tick();
        req = 16'h0000;
        chk("fp_valid", 16'(valid), 16'h0001);
        chk("fp_id2", 16'(id_out), 16'h0002);
        chk("fp_onehot2", onehot_out, 16'h0004);
        chk("fp_pending", pending, 16'h8014);
        ack = 1'b1;
        tick();
        chk("fp_id4", 16'(id_out), 16'h0004);
        chk("fp_pending4", pending, 16'h8010);
        tick();
        chk("fp_id15", 16'(id_out), 16'h000F);
        chk("fp_onehot15", onehot_out, 16'h8000);
        tick();
        chk("fp_drained_valid", 16'(valid), 16'h0000);
        chk("fp_drained_pending", pending, 16'h0000);
        tick();
        chk("ack_idle_valid", 16'(valid), 16'h0000);
        chk("ack_idle_id", 16'(id_out), 16'h000F);

        // round robin with held requests, req wins over clear
        mode = 1'b1;
        req  = 16'h0101;
        tick();
        chk("rr_id0a", 16'(id_out), 16'h0000);
        chk("rr_valid", 16'(valid), 16'h0001);
        tick();
        chk("rr_id8a", 16'(id_out), 16'h0008);
        tick();
        chk("rr_id0b", 16'(id_out), 16'h0000);
        tick();
        chk("rr_id8b", 16'(id_out), 16'h0008);
        chk("rr_pending", pending, 16'h0101);

        // hold rule across req/mask/mode changes
        do_reset();
        req = 16'h0020;
        tick();
        chk("hold_id5", 16'(id_out), 16'h0005);
        req  = 16'h0001;
        mask = 16'h0001;
        for (int i = 0; i < 10; i++) begin
            mode = ~mode;
            tick();
            chk("hold_id", 16'(id_out), 16'h0005);
            chk("hold_valid", 16'(valid), 16'h0001);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("hold_next_id0", 16'(id_out), 16'h0000);
        chk("hold_next_valid", 16'(valid), 16'h0001);

        // masked request stays pending
        do_reset();
        mask = 16'hFFFE;
        req  = 16'h0001;
        tick();
        req = 16'h0000;
        chk("mask_valid", 16'(valid), 16'h0000);
        chk("mask_pending", pending, 16'h0001);
        tick();
        chk("mask_pending_hold", pending, 16'h0001);
        mask = 16'hFFFF;
        tick();
        chk("unmask_valid", 16'(valid), 16'h0001);
        chk("unmask_id0", 16'(id_out), 16'h0000);

        // asynchronous reset mid-handshake
        do_reset();
        req = 16'h00F0;
        tick();
        req = 16'h0000;
        chk("pre_rst_id4", 16'(id_out), 16'h0004);
        chk("pre_rst_pending", pending, 16'h00F0);
        chk("pre_rst_onehot", onehot_out, 16'h0010);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 16'(valid), 16'h0000);
        chk("async_pending", pending, 16'h0000);
        chk("async_onehot", onehot_out, 16'h0000);
        req = 16'hFFFF;
        @(posedge clk);
        #2;
        req   = 16'h0000;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", 16'(valid), 16'h0000);
        chk("post_rst_pending", pending, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
